// File: rtl/rx_word_checker_if.sv
// RX FIFO read-side bundle between the receive word FIFO and rx_word_checker.
// master: FIFO side (presents head word and non-empty flag, takes dequeue strobe).
// slave:  consumer side (samples head word, issues dequeue strobe).
interface rx_word_checker_if;
   logic [31:0] fifo_d_out;
   logic        fifo_empty_n;
   logic        fifo_deq;

   modport master (
      output fifo_d_out,
      output fifo_empty_n,
      input  fifo_deq
   );

   modport slave (
      input  fifo_d_out,
      input  fifo_empty_n,
      output fifo_deq
   );
endinterface

// File: rtl/rx_word_checker.sv
// rx_word_checker: drains the LVDS loop-back RX word FIFO after alignment,
// locks onto the expected stream, counts good words and errors, and drops
// lock after LOSS_THRESH consecutive mismatches.
// Optional build macro RX_CHECK_SEQ_EN: incrementing-sequence mode instead of
// the fixed EXP_WORD pattern.
module rx_word_checker #(
   parameter logic [31:0] EXP_WORD    = 32'h81C3E7FF,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 rx_inclock,
   input  logic                 pll_areset,
   input  logic                 align_done,
   rx_word_checker_if.slave     fifo,
   input  logic                 clr_stats,
   output logic                 locked,
   output logic [CNT_WIDTH-1:0] word_count,
   output logic [CNT_WIDTH-1:0] err_count,
   output logic                 err_flag,
   output logic [31:0]          last_err_word,
   output logic [7:0]           led_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCK   = 2'd2
   } state_t;

   localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

   state_t      state, state_nxt;
   logic [3:0]  miss, miss_nxt;
   logic        take, valid, match, search_hit;
   logic        wc_inc, ec_inc;
   logic [31:0] exp_word;

   assign take          = (state != IDLE) & align_done & fifo.fifo_empty_n;
   assign fifo.fifo_deq = take;
   assign valid         = take & fifo.fifo_d_out[31];
   assign match         = (fifo.fifo_d_out == exp_word);

`ifdef RX_CHECK_SEQ_EN
   logic [30:0] exp_lo;

   assign exp_word   = {1'b1, exp_lo};
   assign search_hit = 1'b1;

   // Expected sequence value: seeded from the locking word, then advances on
   // every valid word in LOCK whether or not it matched.
   always_ff @(posedge rx_inclock or posedge pll_areset) begin
      if (pll_areset) begin
         exp_lo <= '0;
      end else if (valid && state == SEARCH) begin
         exp_lo <= fifo.fifo_d_out[30:0] + 31'd1;
      end else if (valid && state == LOCK) begin
         exp_lo <= exp_lo + 31'd1;
      end
   end
`else
   assign exp_word   = EXP_WORD;
   assign search_hit = match;
`endif

   // FSM state and consecutive-miss counter registers.
   always_ff @(posedge rx_inclock or posedge pll_areset) begin
      if (pll_areset) begin
         state <= IDLE;
         miss  <= '0;
      end else begin
         state <= state_nxt;
         miss  <= miss_nxt;
      end
   end

   // Next-state, miss-counter and statistic-increment decode.
   always_comb begin
      state_nxt = state;
      miss_nxt  = miss;
      wc_inc    = 1'b0;
      ec_inc    = 1'b0;
      if (!align_done) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = SEARCH;
            end
            SEARCH: begin
               miss_nxt = '0;
               if (valid && search_hit) begin
                  state_nxt = LOCK;
                  wc_inc    = 1'b1;
               end
            end
            LOCK: begin
               if (valid) begin
                  if (match) begin
                     wc_inc   = 1'b1;
                     miss_nxt = '0;
                  end else begin
                     ec_inc = 1'b1;
                     if (miss + 4'd1 >= THRESH) begin
                        state_nxt = SEARCH;
                        miss_nxt  = '0;
                     end else begin
                        miss_nxt = miss + 4'd1;
                     end
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Statistics: saturating counters, sticky flag, last bad word; clear wins.
   always_ff @(posedge rx_inclock or posedge pll_areset) begin
      if (pll_areset) begin
         word_count    <= '0;
         err_count     <= '0;
         err_flag      <= 1'b0;
         last_err_word <= '0;
      end else if (clr_stats) begin
         word_count    <= '0;
         err_count     <= '0;
         err_flag      <= 1'b0;
         last_err_word <= '0;
      end else begin
         if (wc_inc && word_count != '1) begin
            word_count <= word_count + 1'b1;
         end
         if (ec_inc) begin
            if (err_count != '1) begin
               err_count <= err_count + 1'b1;
            end
            err_flag      <= 1'b1;
            last_err_word <= fifo.fifo_d_out;
         end
      end
   end

   assign locked  = (state == LOCK);
   assign led_out = {locked, err_flag, err_count[5:0]};

endmodule

// File: tb/tb_rx_word_checker.sv
// Scoreboard bench for rx_word_checker: stimulus pushes FIFO words together
// with hand-computed post-consumption status; a monitor pops and compares
// after every edge on which the DUT dequeued.
module tb_rx_word_checker;

   localparam int CW = 6;

   typedef struct packed {
      logic          lk;
      logic [CW-1:0] wc;
      logic [CW-1:0] ec;
      logic          fl;
      logic [31:0]   last;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          align;
   logic          clr;
   logic          locked;
   logic [CW-1:0] word_count;
   logic [CW-1:0] err_count;
   logic          err_flag;
   logic [31:0]   last_err_word;
   logic [7:0]    led_out;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   exp_t exp_q[$];

   rx_word_checker_if bus ();

   assign bus.fifo_empty_n = (wr_ptr != rd_ptr);
   assign bus.fifo_d_out   = mem[rd_ptr[7:0]];

   rx_word_checker #(
      .EXP_WORD    (32'h81C3E7FF),
      .LOSS_THRESH (4),
      .CNT_WIDTH   (CW)
   ) dut (
      .rx_inclock    (clk),
      .pll_areset    (rst),
      .align_done    (align),
      .fifo          (bus),
      .clr_stats     (clr),
      .locked        (locked),
      .word_count    (word_count),
      .err_count     (err_count),
      .err_flag      (err_flag),
      .last_err_word (last_err_word),
      .led_out       (led_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model read pointer
   always @(posedge clk) begin
      if (bus.fifo_deq) rd_ptr <= rd_ptr + 1;
   end

   // Monitor: compare status after each consuming edge
   initial begin
      logic d;
      exp_t e;
      exp_t a;
      int   n;
      n = 0;
      forever begin
         @(negedge clk);
         d = bus.fifo_deq;
         @(posedge clk);
         #1;
         if (d) begin
            total++;
            a = '{lk: locked, wc: word_count, ec: err_count, fl: err_flag, last: last_err_word};
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL word%0d unexpected dequeue actual=%h required=none", n, a);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  bad++;
                  $display("FAIL word%0d actual lk=%0d wc=%0d ec=%0d fl=%0d last=%h required lk=%0d wc=%0d ec=%0d fl=%0d last=%h",
                           n, a.lk, a.wc, a.ec, a.fl, a.last, e.lk, e.wc, e.ec, e.fl, e.last);
               end
            end
            n++;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send(input logic [31:0] w, input logic lk, input int wc, input int ec,
                       input logic fl, input logic [31:0] last);
      exp_t e;
      e.lk   = lk;
      e.wc   = CW'(wc);
      e.ec   = CW'(ec);
      e.fl   = fl;
      e.last = last;
      exp_q.push_back(e);
      mem[wr_ptr[7:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic drain;
      int k;
      k = 0;
      while (rd_ptr != wr_ptr && k < 300) begin
         @(posedge clk);
         #2;
         k++;
      end
      check("drain", 64'(rd_ptr != wr_ptr), 64'd0);
   endtask

   initial begin
      int wc;
      rst   = 1'b1;
      align = 1'b1;
      clr   = 1'b0;

      // Reset and hold with three (invalid-marker) words waiting
      send(32'h01234567, 1'b0, 0, 0, 1'b0, 32'h0);
      send(32'h01234567, 1'b0, 0, 0, 1'b0, 32'h0);
      send(32'h01234567, 1'b0, 0, 0, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      check("rst_deq",    64'(bus.fifo_deq),    64'd0);
      check("rst_led",    64'(led_out),         64'h00);
      check("rst_wc",     64'(word_count),      64'd0);
      check("rst_ec",     64'(err_count),       64'd0);
      check("rst_last",   64'(last_err_word),   64'd0);
      check("rst_rdptr",  64'(rd_ptr),          64'd0);
      check("rst_avail",  64'(bus.fifo_empty_n), 64'd1);
      rst = 1'b0;
      drain();

`ifdef RX_CHECK_SEQ_EN
      send(32'h80000010, 1'b1, 1, 0, 1'b0, 32'h0);
      send(32'h80000011, 1'b1, 2, 0, 1'b0, 32'h0);
      send(32'h80000013, 1'b1, 2, 1, 1'b1, 32'h80000013);
      send(32'h80000013, 1'b1, 3, 1, 1'b1, 32'h80000013);
      drain();
      clr = 1'b1;
      send(32'h80000099, 1'b1, 0, 0, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      clr = 1'b0;
      send(32'h80000015, 1'b1, 1, 0, 1'b0, 32'h0);
      drain();
      check("seq_led", 64'(led_out), 64'h80);
`else
      // Lock and count
      for (int i = 1; i <= 5; i++) send(32'h81C3E7FF, 1'b1, i, 0, 1'b0, 32'h0);
      drain();
      check("lock_deq",   64'(bus.fifo_deq),     64'd0);
      check("lock_empty", 64'(bus.fifo_empty_n), 64'd0);

      // Loss of lock after four consecutive mismatches
      for (int i = 1; i <= 3; i++) send(32'h81C3E7FE, 1'b1, 5, i, 1'b1, 32'h81C3E7FE);
      send(32'h81C3E7FE, 1'b0, 5, 4, 1'b1, 32'h81C3E7FE);
      drain();
      check("loss_led", 64'(led_out), 64'h44);
      send(32'h81C3E7FF, 1'b1, 6, 4, 1'b1, 32'h81C3E7FE);

      // Invalid-marker words are dequeued but ignored
      send(32'h81C3E7FF, 1'b1, 7, 4, 1'b1, 32'h81C3E7FE);
      send(32'h01234567, 1'b1, 7, 4, 1'b1, 32'h81C3E7FE);
      send(32'h81C3E7FF, 1'b1, 8, 4, 1'b1, 32'h81C3E7FE);
      send(32'h01234567, 1'b1, 8, 4, 1'b1, 32'h81C3E7FE);
      drain();

      // clr_stats coincident with an error word
      clr = 1'b1;
      send(32'h81C3E7FE, 1'b1, 0, 0, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      clr = 1'b0;
      send(32'h81C3E7FF, 1'b1, 1, 0, 1'b0, 32'h0);
      drain();

      // align_done drop with words waiting
      align = 1'b0;
      send(32'h81C3E7FF, 1'b1, 2, 0, 1'b0, 32'h0);
      send(32'h81C3E7FF, 1'b1, 3, 0, 1'b0, 32'h0);
      #1;
      check("drop_deq",   64'(bus.fifo_deq),     64'd0);
      check("drop_avail", 64'(bus.fifo_empty_n), 64'd1);
      @(posedge clk);
      #2;
      check("drop_locked", 64'(locked),          64'd0);
      check("drop_wc",     64'(word_count),      64'd1);
      check("drop_held",   64'(wr_ptr - rd_ptr), 64'd2);
      align = 1'b1;
      drain();

      // word_count saturates at all-ones
      for (int i = 1; i <= 61; i++) begin
         wc = (3 + i > 63) ? 63 : 3 + i;
         send(32'h81C3E7FF, 1'b1, wc, 0, 1'b0, 32'h0);
      end
      drain();
      check("sat_wc",  64'(word_count), 64'd63);
      check("sat_led", 64'(led_out),    64'h80);
`endif

      repeat (2) @(posedge clk);
      #2;
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
